// File: rtl/fw_loader.sv
// fw_loader: streams firmware bytes into 32-bit instruction words, writes them to ROM and holds the CPU in reset until done.
// Optional end-of-image checksum check is enabled by defining FW_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset
// COLLECT | accepting the 4 bytes of the next word (little-endian)
// WRITE   | one-cycle rom_we pulse for the assembled word
// CHECK   | accepting the 4-byte expected sum (checksum build only)
// DONE    | image loaded, CPU released unless the checksum failed
module fw_loader #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    FW_LENGTH     = 8,
  parameter int                    CMD_WIDTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = '0
) (
  input  logic                  clk,
  input  logic                  a_reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [DATA_WIDTH-1:0] rom_wdata,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  checksum_error
);

  localparam int                    WC_W      = (FW_LENGTH > 1) ? $clog2(FW_LENGTH) : 1;
  localparam logic [WC_W-1:0]       WC_LAST   = WC_W'(FW_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(CMD_WIDTH);

`ifdef FW_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

  state_t                  state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [DATA_WIDTH-1:0]   word_asm;
  logic                    byte_ready_q, byte_ready_d;
  logic                    rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0]   rom_address_q, rom_address_d;
  logic [DATA_WIDTH-1:0]   rom_wdata_q, rom_wdata_d;
  logic                    cpu_reset_n_q, cpu_reset_n_d;
  logic                    done_q, done_d;
  logic                    accept;
`ifdef FW_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic                    checksum_error_q, checksum_error_d;
`endif

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    word_cnt_d    = word_cnt_q;
    addr_d        = addr_q;
    word_d        = word_q;
    rom_address_d = rom_address_q;
    rom_wdata_d   = rom_wdata_q;
    cpu_reset_n_d = cpu_reset_n_q;
    done_d        = done_q;
`ifdef FW_LOADER_CHECKSUM_EN
    sum_d            = sum_q;
    checksum_error_d = checksum_error_q;
`endif
    accept   = byte_valid && byte_ready_q;
    word_asm = word_q;
    word_asm[{byte_cnt_q, 3'b000} +: 8] = byte_data;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_COLLECT;
          byte_cnt_d    = '0;
          word_cnt_d    = '0;
          addr_d        = START_ADDRESS;
          done_d        = 1'b0;
          cpu_reset_n_d = 1'b0;
`ifdef FW_LOADER_CHECKSUM_EN
          sum_d            = '0;
          checksum_error_d = 1'b0;
`endif
        end
      end
      S_COLLECT: begin
        if (accept) begin
          word_d     = word_asm;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d       = S_WRITE;
            rom_address_d = addr_q;
            rom_wdata_d   = word_asm;
          end
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_STEP;
`ifdef FW_LOADER_CHECKSUM_EN
        sum_d  = sum_q + rom_wdata_q;
`endif
        if (word_cnt_q == WC_LAST) begin
`ifdef FW_LOADER_CHECKSUM_EN
          state_d       = S_CHECK;
`else
          state_d       = S_DONE;
          done_d        = 1'b1;
          cpu_reset_n_d = 1'b1;
`endif
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = S_COLLECT;
        end
      end
`ifdef FW_LOADER_CHECKSUM_EN
      // The expected sum arrives after the image and is never written to ROM.
      S_CHECK: begin
        if (accept) begin
          word_d     = word_asm;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d          = S_DONE;
            done_d           = 1'b1;
            checksum_error_d = (word_asm != sum_q);
            cpu_reset_n_d    = (word_asm == sum_q);
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef FW_LOADER_CHECKSUM_EN
    byte_ready_d = (state_d == S_COLLECT) || (state_d == S_CHECK);
`else
    byte_ready_d = (state_d == S_COLLECT);
`endif
    rom_we_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= '0;
      word_cnt_q    <= '0;
      addr_q        <= '0;
      word_q        <= '0;
      byte_ready_q  <= 1'b0;
      rom_we_q      <= 1'b0;
      rom_address_q <= '0;
      rom_wdata_q   <= '0;
      cpu_reset_n_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef FW_LOADER_CHECKSUM_EN
      sum_q            <= '0;
      checksum_error_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      word_cnt_q    <= word_cnt_d;
      addr_q        <= addr_d;
      word_q        <= word_d;
      byte_ready_q  <= byte_ready_d;
      rom_we_q      <= rom_we_d;
      rom_address_q <= rom_address_d;
      rom_wdata_q   <= rom_wdata_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      done_q        <= done_d;
`ifdef FW_LOADER_CHECKSUM_EN
      sum_q            <= sum_d;
      checksum_error_q <= checksum_error_d;
`endif
    end
  end

  assign byte_ready  = byte_ready_q;
  assign rom_we      = rom_we_q;
  assign rom_address = rom_address_q;
  assign rom_wdata   = rom_wdata_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign done        = done_q;
`ifdef FW_LOADER_CHECKSUM_EN
  assign checksum_error = checksum_error_q;
`else
  assign checksum_error = 1'b0;
`endif

endmodule

// File: doc/fw_loader.md
FW_LOADER -- requirements
Module: fw_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning instruction word width in bits (fixed 4 bytes).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning instruction memory address width.
REQ-003 SHALL have parameter FW_LENGTH, default 8, meaning number of words loaded per session (>=1).
REQ-004 SHALL have parameter CMD_WIDTH, default 4, meaning address increment per word.
REQ-005 SHALL have parameter START_ADDRESS, default 0, meaning address of first word.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-007 SHALL have port a_reset, input, 1, meaning reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1, meaning request a load session.
REQ-009 SHALL have port byte_valid, input, 1, meaning byte_data valid.
REQ-010 SHALL have port byte_data, input, 8, meaning incoming firmware byte, little-endian within a word.
REQ-011 SHALL have port byte_ready, output, 1, meaning loader accepts a byte this cycle.
REQ-012 SHALL have port rom_we, output, 1, meaning instruction memory write strobe.
REQ-013 SHALL have port rom_address, output, ADDR_WIDTH, meaning write address.
REQ-014 SHALL have port rom_wdata, output, DATA_WIDTH, meaning write data.
REQ-015 SHALL have port cpu_reset_n, output, 1, meaning active-low hold of the CPU core; 0 while loading.
REQ-016 SHALL have port done, output, 1, meaning session complete.
REQ-017 SHALL have port checksum_error, output, 1, meaning checksum mismatch (see Configuration).

Function
REQ-018 SHALL implement states IDLE, COLLECT, WRITE, DONE (plus CHECK when configured); all outputs registered.
REQ-019 IDLE/DONE: byte_ready=0; start=1 SHALL go to COLLECT next cycle, clearing byte count, word count, done, checksum_error, and driving cpu_reset_n=0.
REQ-020 COLLECT: byte_ready=1; a byte SHALL be accepted only when byte_valid&&byte_ready; byte k (0..3) lands in word bits [8k+7:8k].
REQ-021 Acceptance of byte 3 SHALL go to WRITE; byte_valid low SHALL stall with no state change.
REQ-022 WRITE: exactly one cycle with rom_we=1, byte_ready=0, rom_address=START_ADDRESS+word_count*CMD_WIDTH (mod 2^ADDR_WIDTH), rom_wdata=assembled word.
REQ-023 After WRITE: word_count==FW_LENGTH-1 SHALL go to DONE (or CHECK if configured); else word_count+1 and COLLECT.
REQ-024 Latency: last byte accepted in cycle N -> rom_we in N+1 -> done=1 and cpu_reset_n=1 in N+2 (no checksum).
REQ-025 DONE: done=1, cpu_reset_n=1 (unless checksum_error), rom_we=0; held until start or reset.
REQ-026 start in COLLECT, WRITE or CHECK SHALL be ignored.
REQ-027 rom_we=0 in every state except WRITE; rom_address/rom_wdata hold last written values otherwise.

Reset
REQ-028 a_reset=1 SHALL immediately force IDLE, byte_ready=0, rom_we=0, rom_address=0, rom_wdata=0, cpu_reset_n=0, done=0, checksum_error=0, counters 0.
REQ-029 Reset mid-session SHALL abort without further writes; new session requires start after reset release.

Configuration
REQ-030 Macro FW_LOADER_CHECKSUM_EN defined: running 32-bit sum (mod 2^32) of all written words; after final WRITE go to CHECK, collect 4 more bytes (not written to memory) as expected sum, then DONE; mismatch SHALL set checksum_error=1 and keep cpu_reset_n=0; match releases cpu_reset_n=1.
REQ-031 Macro undefined: no CHECK state, no sum register, checksum_error tied 0.

Verification
REQ-032 FW_LENGTH=2, start, bytes 13 00 00 00 93 00 10 00 -> rom_we pulses at 0x0 data 0x00000013, at 0x4 data 0x00100093; done=1, cpu_reset_n=1 two cycles after last byte.
REQ-033 byte_valid gaps of 3 cycles between bytes -> identical writes, byte_ready stays 1, no extra rom_we.
REQ-034 a_reset asserted after 5 bytes -> outputs at reset values immediately; no second rom_we; fresh start reloads from 0x0.
REQ-035 start pulses during COLLECT and WRITE -> ignored, write sequence unchanged; start in DONE -> cpu_reset_n=0 next cycle, reload begins.
REQ-036 With FW_LOADER_CHECKSUM_EN, words 0x00000013, 0x00100093, checksum bytes A6 00 10 00 -> checksum_error=0, cpu_reset_n=1; checksum bytes 00 00 00 00 -> checksum_error=1, cpu_reset_n=0.
REQ-037 START_ADDRESS=0xFFFFFFFC, FW_LENGTH=2 -> second write at 0x00000000 (wrap).
